// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state, mode types and helpers for spi_master_cfg
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam logic [1:0] MODE_0 = 2'b00;
  localparam logic [1:0] MODE_1 = 2'b01;
  localparam logic [1:0] MODE_2 = 2'b10;
  localparam logic [1:0] MODE_3 = 2'b11;

  // A single slave still gets a 1-bit select so the port never collapses to zero width.
  function automatic int cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_master_cfg_if.sv
// rtl/spi_master_cfg_if.sv - command/response bundle between front-end and spi_master_cfg
interface spi_master_cfg_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1
);
  import spi_pkg::*;

  localparam int CS_W = cs_width(NUM_CS);

  logic              start;
  logic [1:0]        mode;
  logic [CS_W-1:0]   cs_sel;
  logic [DATA_W-1:0] data2send;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data2receive;

  modport master (
    output start, mode, cs_sel, data2send,
    input  busy, done, data2receive
  );

  modport slave (
    input  start, mode, cs_sel, data2send,
    output busy, done, data2receive
  );

endinterface

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK divider and edge sequencer for spi_master_cfg
module spi_clk_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic xfer,
  input  logic load,
  input  logic cpol,
  output logic tick,
  output logic lead_pulse,
  output logic trail_pulse,
  output logic last_edge,
  output logic sclk
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);

  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic              xfer_tick;

  assign tick        = run && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign xfer_tick   = xfer && tick;
  // Even edge numbers leave the idle level, odd ones return to it.
  assign lead_pulse  = xfer_tick && !edge_cnt[0];
  assign trail_pulse = xfer_tick && edge_cnt[0];
  assign last_edge   = (edge_cnt == EDGE_W'(2 * DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!run || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (!xfer) begin
      edge_cnt <= '0;
    end else if (tick) begin
      edge_cnt <= edge_cnt + EDGE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk <= 1'b0;
    end else if (load) begin
      sclk <= cpol;
    end else if (xfer_tick) begin
      sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - run-time configurable SPI master, one full-duplex word per start
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int NUM_CS    = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_cfg_if.slave   cmd,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs
);

  localparam int CS_W = cs_width(NUM_CS);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_SETUP = SETUP;
  localparam logic [2:0] ST_XFER  = XFER;
  localparam logic [2:0] ST_HOLD  = HOLD;
  localparam logic [2:0] ST_DONE  = DONE;

  logic [2:0]        state;
  logic              cpha_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              done_q;
  logic [DATA_W-1:0] rx_q;

  spi_mode_t         mode_in;
  logic [DATA_W-1:0] tx_ordered;
  logic              accept;
  logic              run;
  logic              tick;
  logic              lead_pulse;
  logic              trail_pulse;
  logic              last_edge;
  logic              sample_edge;
  logic              shift_edge;

  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = w[DATA_W-1-i];
    end
    return r;
  endfunction

  // A select beyond NUM_CS matches no line, so the frame runs with every cs released.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      r[i] = (sel != CS_W'(i));
    end
    return r;
  endfunction

  assign mode_in    = spi_mode_t'(cmd.mode);
  // Internally the word is always shifted MSB first; LSB-first is a reversal at the edges.
  assign tx_ordered = MSB_FIRST ? cmd.data2send : bit_reverse(cmd.data2send);
  assign accept     = cmd.start && (state == ST_IDLE) && !done_q;
  assign run        = (state == ST_SETUP) || (state == ST_XFER) || (state == ST_HOLD);
  assign sample_edge = cpha_q ? trail_pulse : lead_pulse;
  assign shift_edge  = cpha_q ? lead_pulse : (trail_pulse && !last_edge);

  assign cmd.busy         = (state != ST_IDLE) || done_q;
  assign cmd.done         = done_q;
  assign cmd.data2receive = rx_q;

  spi_clk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .xfer        (state == ST_XFER),
    .load        (accept),
    .cpol        (mode_in.cpol),
    .tick        (tick),
    .lead_pulse  (lead_pulse),
    .trail_pulse (trail_pulse),
    .last_edge   (last_edge),
    .sclk        (sclk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cpha_q <= 1'b0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      done_q <= 1'b0;
      rx_q   <= '0;
      mosi   <= 1'b0;
      cs     <= '1;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cpha_q <= mode_in.cpha;
            // CPHA=1 re-drives the first bit on the first leading edge, so keep it in the register.
            tx_sr  <= mode_in.cpha ? tx_ordered : (tx_ordered << 1);
            rx_sr  <= '0;
            mosi   <= tx_ordered[DATA_W-1];
            cs     <= cs_decode(cmd.cs_sel);
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (sample_edge) begin
            rx_sr <= {rx_sr[DATA_W-2:0], miso};
          end
          if (shift_edge) begin
            mosi  <= tx_sr[DATA_W-1];
            tx_sr <= tx_sr << 1;
          end
          if (tick && last_edge) begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          cs     <= '1;
          mosi   <= 1'b0;
          done_q <= 1'b1;
          rx_q   <= MSB_FIRST ? rx_sr : bit_reverse(rx_sr);
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
